uart_rx_fifo: RTL and testbench

//  Parametrised UART receiver: configurable data bits, parity, stop bits, with a

---
 rtl/uart_rx_fifo.sv | 199 +++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver with configurable data/parity/stop format feeding a small receive FIFO.
// Each stored word carries its own parity and framing status to the consumer.
module uart_rx_fifo #(
  parameter int unsigned CLOCK_FREQ = 50000000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 rx,
  output logic [DATA_BITS-1:0]                 data_out,
  output logic                                 data_valid,
  input  logic                                 data_ready,
  output logic                                 parity_err,
  output logic                                 frame_err,
  output logic                                 overrun,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_count
);

  localparam int unsigned CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned HALF         = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W        = 4;
  localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_FW       = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned ENTRY_W      = DATA_BITS + 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state_q, state_d;
  logic                 rx_meta, rx_s;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [1:0]           samp_q, samp_d;
  logic                 pe_q, pe_d;
  logic                 fe_q, fe_d;
  logic                 tick_c, bit_c, push_c;
  logic [ENTRY_W-1:0]   entry_c;

  logic [ENTRY_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_FW-1:0]    count_d;
  logic                 pop_c, full_c, wr_en_c;
  logic [ENTRY_W-1:0]   head_c;

  // Two-flop synchroniser; idles high so reset does not look like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Decision point is the third of three mid-bit samples.
  assign tick_c = (cnt_q == CNT_W'(HALF + 1));
  assign bit_c  = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      samp_q  <= '0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      samp_q  <= samp_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    samp_d  = samp_q;
    pe_d    = pe_q;
    fe_d    = fe_q;
    push_c  = 1'b0;

    if (state_q != S_IDLE)
      cnt_d = (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) ? '0 : cnt_q + CNT_W'(1);
    if (cnt_q == CNT_W'(HALF - 1)) samp_d[0] = rx_s;
    if (cnt_q == CNT_W'(HALF))     samp_d[1] = rx_s;

    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (tick_c) begin
          if (bit_c) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            idx_d   = '0;
            pe_d    = 1'b0;
            fe_d    = 1'b0;
          end
        end
      end
      S_DATA: begin
        if (tick_c) begin
          shift_d = {bit_c, shift_q[DATA_BITS-1:1]};
          if (idx_q == IDX_W'(DATA_BITS - 1)) begin
            idx_d   = '0;
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (tick_c) begin
          pe_d    = (PARITY == 1) ? ~(^shift_q ^ bit_c) : (^shift_q ^ bit_c);
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (tick_c) begin
          if (!bit_c) fe_d = 1'b1;
          if (idx_q == IDX_W'(STOP_BITS - 1)) begin
            push_c  = 1'b1;
            idx_d   = '0;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    entry_c = {fe_d, pe_q, shift_q};
  end

  // FIFO bookkeeping; a push into a full FIFO is kept only if the head pops the same cycle.
  always_comb begin
    pop_c    = data_valid && data_ready;
    full_c   = (fifo_count == CNT_FW'(FIFO_DEPTH));
    wr_en_c  = push_c && (!full_c || pop_c);
    rd_ptr_d = pop_c   ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    wr_ptr_d = wr_en_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    case ({wr_en_c, pop_c})
      2'b10:   count_d = fifo_count + CNT_FW'(1);
      2'b01:   count_d = fifo_count - CNT_FW'(1);
      default: count_d = fifo_count;
    endcase
    head_c = (wr_en_c && (wr_ptr_q == rd_ptr_d)) ? entry_c : mem[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (wr_en_c) mem[wr_ptr_q] <= entry_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_count <= '0;
      data_valid <= 1'b0;
      data_out   <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_count <= count_d;
      data_valid <= (count_d != '0);
      {frame_err, parity_err, data_out} <= (count_d != '0) ? head_c : '0;
      overrun    <= push_c && full_c && !pop_c;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed and randomised serial frames into two receivers (8N1 and 8E1),
// compared against a queue-based model of the expected word stream.
module tb_uart_rx_fifo;

  localparam int unsigned CPB   = 434;
  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx0, ready0, valid0, pe0, fe0, ov0;
  logic       rx1, ready1, valid1, pe1, fe1, ov1;
  logic [7:0] dout0, dout1;
  logic [2:0] cnt0, cnt1;

  int vectors = 0;
  int miscompares = 0;

  always #10 clk = ~clk;

  uart_rx_fifo u_dut0 (
    .clk(clk), .rst_n(rst_n), .rx(rx0), .data_out(dout0), .data_valid(valid0),
    .data_ready(ready0), .parity_err(pe0), .frame_err(fe0), .overrun(ov0), .fifo_count(cnt0)
  );

  uart_rx_fifo #(.PARITY(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .rx(rx1), .data_out(dout1), .data_valid(valid1),
    .data_ready(ready1), .parity_err(pe1), .frame_err(fe1), .overrun(ov1), .fifo_count(cnt1)
  );

  // Observation: words handed over, valid cycles, overrun pulses, head stability while stalled.
  logic [9:0] got0[$], got1[$];
  int vcyc0 = 0, ovn0 = 0, viol0 = 0, ovn1 = 0, viol1 = 0;
  logic       hold0 = 1'b0, hold1 = 1'b0;
  logic [9:0] prev0 = '0, prev1 = '0;

  always @(negedge clk) begin
    if (valid0 && ready0) got0.push_back({fe0, pe0, dout0});
    if (valid0) vcyc0++;
    if (ov0) ovn0++;
    if (hold0 && rst_n && ({fe0, pe0, dout0} !== prev0)) viol0++;
    hold0 = valid0 && !ready0 && rst_n;
    prev0 = {fe0, pe0, dout0};
  end

  always @(negedge clk) begin
    if (valid1 && ready1) got1.push_back({fe1, pe1, dout1});
    if (ov1) ovn1++;
    if (hold1 && rst_n && ({fe1, pe1, dout1} !== prev1)) viol1++;
    hold1 = valid1 && !ready1 && rst_n;
    prev1 = {fe1, pe1, dout1};
  end

  // Reference model: expected words in order, FIFO occupancy, expected overruns.
  logic [9:0] exp0[$], exp1[$];
  int occ0 = 0, occ1 = 0, ovexp0 = 0, ovexp1 = 0, rd0 = 0, rd1 = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] word(input bit sel, input logic [7:0] d, input logic p,
                                      input logic stop_v);
    logic perr;
    // Even parity: the data plus parity bit must hold an even number of ones.
    perr = sel ? ($countones({d, p}) % 2 == 1) : 1'b0;
    return {~stop_v, perr, d};
  endfunction

  task automatic model_push(input bit sel, input logic [9:0] w);
    if (!sel) begin
      if (occ0 < DEPTH) begin occ0++; exp0.push_back(w); end
      else ovexp0++;
      if (ready0) occ0 = 0;
    end else begin
      if (occ1 < DEPTH) begin occ1++; exp1.push_back(w); end
      else ovexp1++;
      if (ready1) occ1 = 0;
    end
  endtask

  task automatic drive(input bit sel, input logic b);
    if (sel) rx1 = b; else rx0 = b;
    tick(CPB);
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input logic p,
                            input logic stop_v);
    if (sel ? ready1 : ready0) begin
      if (sel) occ1 = 0; else occ0 = 0;
    end
    drive(sel, 1'b0);
    for (int i = 0; i < 8; i++) drive(sel, d[i]);
    if (sel) drive(sel, p);
    drive(sel, stop_v);
    model_push(sel, word(sel, d, p, stop_v));
  endtask

  task automatic drain();
    ready0 = 1'b1;
    ready1 = 1'b1;
    tick(2 * DEPTH + 4);
    occ0 = 0;
    occ1 = 0;
  endtask

  task automatic check_words(input string tag);
    check({tag, "_count0"}, 32'(got0.size() - rd0), 32'(exp0.size()));
    foreach (exp0[i]) begin
      if (rd0 < got0.size()) begin
        check({tag, "_word0"}, 32'(got0[rd0]), 32'(exp0[i]));
        rd0++;
      end
    end
    rd0 = got0.size();
    exp0.delete();
    check({tag, "_count1"}, 32'(got1.size() - rd1), 32'(exp1.size()));
    foreach (exp1[i]) begin
      if (rd1 < got1.size()) begin
        check({tag, "_word1"}, 32'(got1[rd1]), 32'(exp1[i]));
        rd1++;
      end
    end
    rd1 = got1.size();
    exp1.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"},  32'(dout0), 32'd0);
    check({tag, "_valid"}, 32'(valid0), 32'd0);
    check({tag, "_flags"}, 32'({pe0, fe0, ov0}), 32'd0);
    check({tag, "_count"}, 32'(cnt0), 32'd0);
    check({tag, "_dut1"},  32'({dout1, valid1, pe1, fe1, ov1, cnt1}), 32'd0);
  endtask

  int base;

  initial begin
    rst_n  = 1'b0;
    rx0    = 1'b1;
    rx1    = 1'b1;
    ready0 = 1'b0;
    ready1 = 1'b0;
    tick(5);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick(5);

    // T1: single clean 8N1 frame, consumer always ready.
    ready0 = 1'b1;
    base = vcyc0;
    send_frame(0, 8'hA5, 1'b0, 1'b1);
    tick(4);
    check("t1_valid_cycles", 32'(vcyc0 - base), 32'd1);
    check_words("t1");

    // T2 on the even-parity receiver alongside T3 on the 8N1 receiver.
    ready1 = 1'b1;
    fork
      begin
        send_frame(1, 8'h07, 1'b1, 1'b1);
        send_frame(1, 8'h07, 1'b0, 1'b1);
      end
      begin
        send_frame(0, 8'h3C, 1'b0, 1'b0);
        drive(0, 1'b1);
        send_frame(0, 8'h11, 1'b0, 1'b1);
      end
    join
    tick(4);
    check_words("t2_t3");

    // T4: short low glitch must not start a frame.
    base = ovn0;
    rx0 = 1'b0;
    tick(100);
    rx0 = 1'b1;
    tick(2 * CPB);
    check("t4_count", 32'(cnt0), 32'd0);
    check("t4_valid", 32'(valid0), 32'd0);
    check("t4_overrun", 32'(ovn0 - base), 32'd0);
    check_words("t4");

    // T5: stalled consumer, five back-to-back frames into a four-entry FIFO.
    ready0 = 1'b0;
    base = ovn0;
    for (int i = 1; i <= 5; i++) send_frame(0, 8'(i), 1'b0, 1'b1);
    tick(2);
    check("t5_count", 32'(cnt0), 32'(occ0));
    check("t5_overrun", 32'(ovn0 - base), 32'(ovexp0));
    check("t5_valid", 32'(valid0), 32'd1);
    check("t5_head", 32'({fe0, pe0, dout0}), 32'(exp0[0]));
    drain();
    check("t5_drained", 32'(cnt0), 32'd0);
    check_words("t5");

    // T6: reset in the middle of a frame with a word already stored.
    ready0 = 1'b0;
    send_frame(0, 8'h33, 1'b0, 1'b1);
    check("t6_pre_count", 32'(cnt0), 32'd1);
    drive(0, 1'b0);
    for (int i = 0; i < 4; i++) drive(0, 1'b1);
    rst_n = 1'b0;
    tick(3);
    check_reset_outputs("t6_reset");
    exp0.delete();
    occ0 = 0;
    rd0 = got0.size();
    rst_n = 1'b1;
    rx0 = 1'b1;
    tick(2 * CPB);
    ready0 = 1'b1;
    send_frame(0, 8'h5A, 1'b0, 1'b1);
    tick(4);
    check_words("t6");

    // Random frames with random consumer readiness and idle gaps.
    fork
      for (int k = 0; k < 2; k++) begin
        ready0 = 1'($urandom);
        if ($urandom_range(0, 1) == 1) drive(0, 1'b1);
        send_frame(0, 8'($urandom), 1'b0, 1'b1);
      end
      for (int k = 0; k < 2; k++) begin
        ready1 = 1'($urandom);
        if ($urandom_range(0, 1) == 1) drive(1, 1'b1);
        send_frame(1, 8'($urandom), 1'($urandom), 1'b1);
      end
    join
    drain();
    check_words("rand");
    check("overrun_total0", 32'(ovn0), 32'(ovexp0));
    check("overrun_total1", 32'(ovn1), 32'(ovexp1));
    check("hold_stable0", 32'(viol0), 32'd0);
    check("hold_stable1", 32'(viol1), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
